fp_normalize_round: RTL



---
 rtl/fp_normalize_round_if.sv | 25 ++
 rtl/fp_normalize_round.sv | 106 ++++++++++
 2 files changed

// File: rtl/fp_normalize_round_if.sv
// Handshake bundle between the sign-magnitude stage, the normalise/round
// stage and the downstream consumer.
interface fp_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [11:0] sign_mag;
  logic        out_valid;
  logic        out_ready;
  logic        fp_sign;
  logic [2:0]  fp_exp;
  logic [3:0]  fp_sig;

  // Driver side: the upstream producer and the downstream consumer
  modport master (
    output in_valid, sign, sign_mag, out_ready,
    input  in_ready, out_valid, fp_sign, fp_exp, fp_sig
  );

  // The normalise/round block itself
  modport slave (
    input  in_valid, sign, sign_mag, out_ready,
    output in_ready, out_valid, fp_sign, fp_exp, fp_sig
  );
endinterface

// File: rtl/fp_normalize_round.sv
// Normalise and round a 12-bit sign-magnitude value into 1/3/4 floating point.
// The normaliser shifts one bit per cycle until the leading one reaches bit 10
// or the exponent reaches zero; a rounding step then produces the significand.
// Build option: define FP_ROUND_EN for round-half-up with exponent carry and
// saturation; leave it undefined for plain truncation (same latency).
module fp_normalize_round (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_normalize_round_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state_q;
  logic [10:0] w_q;
  logic [2:0]  e_q;
  logic        s_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        fp_sign_q;
  logic [2:0]  fp_exp_q;
  logic [3:0]  fp_sig_q;

  logic [3:0]  sig_d;
  logic [2:0]  exp_d;

  // Upstream guarantees bit 11 is zero; it carries no information.
  logic unused_mag_msb;
  assign unused_mag_msb = bus.sign_mag[11];

  // Rounding result from the normalised window: sig = w[10:7], round bit w[6]
  always_comb begin
    sig_d = w_q[10:7];
    exp_d = e_q;
`ifdef FP_ROUND_EN
    if (w_q[6]) begin
      if (w_q[10:7] != 4'b1111) begin
        sig_d = w_q[10:7] + 4'd1;
      end else if (e_q != 3'd7) begin
        sig_d = 4'b1000;
        exp_d = e_q + 3'd1;
      end else begin
        sig_d = 4'b1111;
        exp_d = 3'd7;
      end
    end
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fp_sign_q   <= 1'b0;
      fp_exp_q    <= '0;
      fp_sig_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            w_q        <= bus.sign_mag[10:0];
            e_q        <= 3'd7;
            s_q        <= bus.sign;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_q[10] && (e_q != 3'd0)) begin
            w_q <= {w_q[9:0], 1'b0};
            e_q <= e_q - 3'd1;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          fp_sig_q    <= sig_d;
          fp_exp_q    <= exp_d;
          fp_sign_q   <= s_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fp_sign   = fp_sign_q;
  assign bus.fp_exp    = fp_exp_q;
  assign bus.fp_sig    = fp_sig_q;

endmodule
